// File: rtl/text_loader.sv
// Byte-stream loader for the encoder's token matcher: fills the input RAM, appends a
// 0x00 terminator, then holds cs until match_done. TEXT_LOADER_CASEFOLD_EN lowercases A..Z.
module text_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cs,
  input  logic                  match_done,
  output logic [ADDR_WIDTH-1:0] len,
  output logic                  overflow
);

  // The top address is kept free so the terminator always has a slot.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {LOAD, TERM, RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    cs_q, cs_d;
  logic                    overflow_q, overflow_d;

  function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] d);
`ifdef TEXT_LOADER_CASEFOLD_EN
    if (d >= DATA_WIDTH'(8'h41) && d <= DATA_WIDTH'(8'h5A))
      return d + DATA_WIDTH'(8'h20);
    return d;
`else
    return d;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cs_d        = cs_q;
    overflow_d  = overflow_q;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          // Nulls are skipped: an embedded 0x00 would truncate the matcher input.
          if (s_data != '0) begin
            if (wr_ptr_q == LAST_ADDR) begin
              overflow_d = 1'b1;
            end else begin
              ram_we_d    = 1'b1;
              ram_addr_d  = wr_ptr_q;
              ram_wdata_d = fold(s_data);
              wr_ptr_d    = wr_ptr_q + 1'b1;
            end
          end
          if (s_last) state_d = TERM;
        end
      end
      TERM: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = wr_ptr_q;
        ram_wdata_d = '0;
        state_d     = RUN;
      end
      RUN: begin
        cs_d = 1'b1;
        if (match_done) begin
          cs_d       = 1'b0;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
          state_d    = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cs_q        <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cs_q        <= cs_d;
      overflow_q  <= overflow_d;
    end
  end

  // wr_ptr only advances on payload writes, so it doubles as the payload length.
  assign s_ready   = (state_q == LOAD);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cs        = cs_q;
  assign len       = wr_ptr_q;
  assign overflow  = overflow_q;

endmodule
